booth_multiplier_32: RTL and testbench
======================================

BOOTH_MULTIPLIER_32 -- requirements
Module: booth_multiplier_32

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 SHALL have port clk, input, 1 bit: the only clock, all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_x, input, 32 bits: multiplicand, signed two's complement.
REQ-005 SHALL have port in_y, input, 32 bits: multiplier, signed two's complement; this operand is recoded.
REQ-006 SHALL have port out_product, output, 64 bits: registered signed product in_x*in_y.
REQ-007 SHALL have no parameters; all widths are fixed.

Function
REQ-008 SHALL compute the full 64-bit two's-complement product of signed in_x and in_y; the result is exact for all operand pairs, with no overflow or truncation.
REQ-009 SHALL recode the multiplier by bit pairs (radix-4 Booth), with a 0 appended below in_y[0], giving 16 overlapping triplets. Triplet i is {in_y[2i+1], in_y[2i], in_y[2i-1]}, with in_y[-1] = 0.
REQ-010 SHALL map each triplet to a digit: 000 and 111 -> 0; 001 and 010 -> +x; 011 -> +2x; 100 -> -2x; 101 and 110 -> -x.
REQ-011 SHALL form each partial product as the digit times in_x, sign-extended to 64 bits and shifted left by 2i. Negation is exact two's complement, including -2x at x = 0x80000000.
REQ-012 SHALL reduce the 16 partial products through three levels of 4:2 compression (16->8->4->2). Each compressor outputs sum and carry vectors whose total equals the total of its 4 inputs modulo 2^64. Carries beyond bit 63 are discarded.
REQ-013 SHALL add the final two vectors in a 64-bit carry-propagate adder built from two 32-bit adders. The low adder has carry-in 0; its carry-out feeds the high adder; the high carry-out is discarded.
REQ-014 SHALL update out_product on every rising clk edge with the product of the in_x and in_y sampled at that edge. Latency is 1 cycle, throughput is 1 result per cycle, and there is no handshake.
REQ-015 SHALL keep the combinational path from inputs to the product register free of latches and feedback.

Reset
REQ-016 SHALL clear out_product to 64'h0 immediately on reset assertion, independent of clk.
REQ-017 SHALL hold out_product at 0 while reset is high, even if inputs change.
REQ-018 SHALL capture the product at the first rising clk edge after reset deasserts. An operation in flight when reset asserts is lost.

Structure
REQ-019 SHALL implement the radix-4 digit encoding (0, +x, +2x, -x, -2x) as constants in a shared package used by the recoder.
REQ-020 SHALL use the sub-module bit_pair_recoder_32: inputs are the 32-bit multiplicand and a 3-bit triplet; output is a 64-bit sign-extended partial product.
REQ-021 SHALL use the sub-module reducer_64: inputs are four 64-bit vectors plus cin; outputs are 64-bit sum, 64-bit carry and cout. It is built from a pair of chained full-adder rows per bit. cin is tied to 0 and cout is unused.
REQ-022 SHALL use the sub-module adder_32: inputs are two 32-bit operands and a carry-in; outputs are a 32-bit sum and a carry-out.
REQ-023 SHALL contain only the recoders, reducers, adders and the output register in the top level.

Verification
REQ-024 SHALL pass this scenario after reset release: in_x = 0x0000000A, in_y = 0x0000000A -> out_product = 0x0000000000000064 one cycle later.
REQ-025 SHALL pass this scenario: in_x = 0x00000061, in_y = 0x00000056 -> out_product = 0x0000000000002096 (decimal 8342).
REQ-026 SHALL pass this scenario: in_x = 0xFFFFFFF3 (-13), in_y = 0x0000000B -> out_product = 0xFFFFFFFFFFFFFF71 (-143).
REQ-027 SHALL pass these boundary cases:
- 0x80000000 * 0x80000000 -> 0x4000000000000000.
- 0xFFFFFFFF * 0xFFFFFFFF -> 0x0000000000000001.
- 0x7FFFFFFF * 0x80000000 -> 0xC000000080000000.
REQ-028 SHALL pass this pipeline case: back-to-back new operands every cycle -> each product appears exactly 1 cycle after its operands.
REQ-029 SHALL pass this reset case: assert reset between clk edges with a nonzero product held -> out_product reads 0 immediately and stays 0 until the first edge after release.
REQ-030 SHALL match a behavioural signed-multiply reference model on at least 10,000 random operand pairs.

Source files
------------

// File: rtl/booth_multiplier_32_pkg.sv
// rtl/booth_multiplier_32_pkg.sv - radix-4 Booth digit encoding and triplet decode
package booth_multiplier_32_pkg;

  localparam int unsigned XW = 32;
  localparam int unsigned PW = 64;
  localparam int unsigned NUM_PP = 16;

  // Radix-4 Booth digit applied to the multiplicand
  typedef enum logic [2:0] {
    DIG_ZERO = 3'd0,
    DIG_P1   = 3'd1,
    DIG_P2   = 3'd2,
    DIG_M1   = 3'd3,
    DIG_M2   = 3'd4
  } digit_e;

  // Triplet {y[2i+1], y[2i], y[2i-1]} to its Booth digit
  function automatic digit_e decode_triplet(input logic [2:0] t);
    case (t)
      3'b001, 3'b010: return DIG_P1;
      3'b011:         return DIG_P2;
      3'b100:         return DIG_M2;
      3'b101, 3'b110: return DIG_M1;
      default:        return DIG_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/adder_32.sv
// rtl/adder_32.sv - 32-bit carry-propagate adder slice
module adder_32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  // Plain ripple/CPA add, tool picks the structure
  always_comb begin
    {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'd0, cin_i};
  end

endmodule

// File: rtl/bit_pair_recoder_32.sv
// rtl/bit_pair_recoder_32.sv - one Booth triplet to a sign-extended 64-bit partial product
module bit_pair_recoder_32
  import booth_multiplier_32_pkg::*;
(
  input  logic [XW-1:0] x_i,
  input  logic [2:0]    triplet_i,
  output logic [PW-1:0] pp_o
);

  logic [PW-1:0] x_ext;
  digit_e        digit;

  assign x_ext = {{(PW-XW){x_i[XW-1]}}, x_i};
  assign digit = decode_triplet(triplet_i);

  // Select digit multiple; 64-bit width keeps -2x exact for x = 0x80000000
  always_comb begin
    pp_o = '0;
    case (digit)
      DIG_P1:  pp_o = x_ext;
      DIG_P2:  pp_o = x_ext << 1;
      DIG_M1:  pp_o = -x_ext;
      DIG_M2:  pp_o = -(x_ext << 1);
      default: pp_o = '0;
    endcase
  end

endmodule

// File: rtl/reducer_64.sv
// rtl/reducer_64.sv - 64-bit 4:2 compressor built from two chained full-adder rows
module reducer_64
  import booth_multiplier_32_pkg::*;
(
  input  logic [PW-1:0] a_i,
  input  logic [PW-1:0] b_i,
  input  logic [PW-1:0] c_i,
  input  logic [PW-1:0] d_i,
  input  logic          cin_i,
  output logic [PW-1:0] sum_o,
  output logic [PW-1:0] carry_o,
  output logic          cout_o
);

  logic [PW-1:0] s1, c1, t, c2;

  // First row: a+b+c; second row: s1+d+carry from the first row of the bit below
  always_comb begin
    s1 = a_i ^ b_i ^ c_i;
    c1 = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    t  = {c1[PW-2:0], cin_i};
    sum_o = s1 ^ d_i ^ t;
    c2 = (s1 & d_i) | (s1 & t) | (d_i & t);
    // carry_o is already aligned to its weight; bit 63 carries fall off
    carry_o = {c2[PW-2:0], 1'b0};
    cout_o  = c1[PW-1];
  end

endmodule

// File: rtl/booth_multiplier_32.sv
// rtl/booth_multiplier_32.sv - single-cycle radix-4 Booth signed 32x32 multiplier
module booth_multiplier_32
  import booth_multiplier_32_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic [XW-1:0] in_x,
  input  logic [XW-1:0] in_y,
  output logic [PW-1:0] out_product
);

  logic [XW:0]   y_ext;
  logic [PW-1:0] pp_raw [NUM_PP];
  logic [PW-1:0] pp     [NUM_PP];
  logic [PW-1:0] l1     [8];
  logic [PW-1:0] l2     [4];
  logic [PW-1:0] sum_v, carry_v;
  logic [3:0]    cout_l1;
  logic [1:0]    cout_l2;
  logic          cout_l3;
  logic [31:0]   lo_sum, hi_sum;
  logic          lo_cout, hi_cout;
  logic [PW-1:0] product_d, product_q;
  logic          unused_couts;

  // Implicit y[-1] = 0 below the multiplier
  assign y_ext = {in_y, 1'b0};

  for (genvar i = 0; i < NUM_PP; i++) begin : g_pp
    bit_pair_recoder_32 u_rec (
      .x_i      (in_x),
      .triplet_i(y_ext[2*i+2 -: 3]),
      .pp_o     (pp_raw[i])
    );
    assign pp[i] = pp_raw[i] << (2 * i);
  end

  for (genvar j = 0; j < 4; j++) begin : g_l1
    reducer_64 u_red (
      .a_i(pp[4*j]), .b_i(pp[4*j+1]), .c_i(pp[4*j+2]), .d_i(pp[4*j+3]),
      .cin_i(1'b0), .sum_o(l1[2*j]), .carry_o(l1[2*j+1]), .cout_o(cout_l1[j])
    );
  end

  for (genvar k = 0; k < 2; k++) begin : g_l2
    reducer_64 u_red (
      .a_i(l1[4*k]), .b_i(l1[4*k+1]), .c_i(l1[4*k+2]), .d_i(l1[4*k+3]),
      .cin_i(1'b0), .sum_o(l2[2*k]), .carry_o(l2[2*k+1]), .cout_o(cout_l2[k])
    );
  end

  reducer_64 u_red_l3 (
    .a_i(l2[0]), .b_i(l2[1]), .c_i(l2[2]), .d_i(l2[3]),
    .cin_i(1'b0), .sum_o(sum_v), .carry_o(carry_v), .cout_o(cout_l3)
  );

  adder_32 u_add_lo (
    .a_i(sum_v[31:0]), .b_i(carry_v[31:0]), .cin_i(1'b0),
    .sum_o(lo_sum), .cout_o(lo_cout)
  );

  adder_32 u_add_hi (
    .a_i(sum_v[63:32]), .b_i(carry_v[63:32]), .cin_i(lo_cout),
    .sum_o(hi_sum), .cout_o(hi_cout)
  );

  // Carries past bit 63 are meaningless modulo 2^64
  assign unused_couts = ^{cout_l1, cout_l2, cout_l3, hi_cout};

  assign product_d = {hi_sum, lo_sum};

  // Product register, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) product_q <= '0;
    else       product_q <= product_d;
  end

  assign out_product = product_q;

endmodule

// File: tb/tb_booth_multiplier_32.sv
// tb/tb_booth_multiplier_32.sv - scoreboard bench for booth_multiplier_32
module tb_booth_multiplier_32;

  logic        clk;
  logic        reset;
  logic [31:0] in_x;
  logic [31:0] in_y;
  logic [63:0] out_product;

  int checks;
  int errors;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];

  booth_multiplier_32 dut (
    .clk        (clk),
    .reset      (reset),
    .in_x       (in_x),
    .in_y       (in_y),
    .out_product(out_product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xe, ye;
    xe = {{32{x[31]}}, x};
    ye = {{32{y[31]}}, y};
    return xe * ye;
  endfunction

  // Drive at negedge, push expectation, then compare one edge later
  task automatic apply(input string tag, input logic [31:0] x, input logic [31:0] y);
    sb_entry_t e;
    @(negedge clk);
    in_x = x;
    in_y = y;
    e.tag = tag;
    e.exp = ref_mul(x, y);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq(e.tag, out_product, e.exp);
    end
  endtask

  task automatic apply_const(input string tag, input logic [31:0] x, input logic [31:0] y,
                             input logic [63:0] want);
    @(negedge clk);
    in_x = x;
    in_y = y;
    @(posedge clk);
    #1;
    check_eq(tag, out_product, want);
  endtask

  logic [31:0] rx, ry;
  logic [31:0] corners [6];

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    in_x   = 32'h1234_5678;
    in_y   = 32'h0000_0003;
    corners[0] = 32'h8000_0000;
    corners[1] = 32'h7FFF_FFFF;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h0000_0000;
    corners[4] = 32'h0000_0001;
    corners[5] = 32'h5555_5555;

    #1;
    check_eq("reset_state", out_product, 64'h0);
    @(posedge clk);
    #1;
    check_eq("reset_hold_edge", out_product, 64'h0);

    @(negedge clk);
    reset = 1'b0;

    apply_const("x10_y10", 32'h0000_000A, 32'h0000_000A, 64'h0000_0000_0000_0064);
    apply_const("x97_y86", 32'h0000_0061, 32'h0000_0056, 64'h0000_0000_0000_2096);
    apply_const("neg13_y11", 32'hFFFF_FFF3, 32'h0000_000B, 64'hFFFF_FFFF_FFFF_FF71);
    apply_const("min_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    apply_const("m1_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    apply_const("max_min", 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
    apply_const("min_m2", 32'h8000_0000, 32'hFFFF_FFFE, 64'h0000_0001_0000_0000);
    apply_const("zero_x", 32'h0000_0000, 32'hDEAD_BEEF, 64'h0);

    // Back-to-back: new operands every cycle, each checked one edge later
    for (int i = 0; i < 8; i++) begin
      apply("b2b", 32'(i * 32'h1111_1111), 32'hFFFF_FFF0 + 32'(i));
    end

    // Asynchronous reset mid-cycle with a nonzero product held
    apply_const("pre_reset", 32'h0000_1000, 32'h0000_0100, 64'h0000_0000_0010_0000);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_clear", out_product, 64'h0);
    in_x = 32'h0000_0007;
    in_y = 32'h0000_0009;
    @(posedge clk);
    #1;
    check_eq("reset_inputs_change", out_product, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("released_before_edge", out_product, 64'h0);
    @(posedge clk);
    #1;
    check_eq("first_after_release", out_product, 64'h0000_0000_0000_003F);

    // Random operands, with corner values mixed in
    for (int i = 0; i < 10000; i++) begin
      rx = $urandom();
      ry = $urandom();
      if ($urandom_range(0, 7) == 0) rx = corners[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) ry = corners[$urandom_range(0, 5)];
      apply("random", rx, ry);
    end

    if (sb_q.size() != 0) check_eq("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
